ps2_key_decoder: RTL and testbench
==================================

Name: ps2_key_decoder

Overview:
Parametrised second-generation PS/2 keyboard receiver. It oversamples ps2_clk and ps2_data on the system clock and deframes 11-bit packets with a state machine, including parity, stop-bit and timeout checking. It resolves E0 (extended) and F0 (break) prefixes into complete key events and tracks make/break state for NUM_KEYS configurable watched keys. It sits between the keyboard pins and game/control logic, replacing the fixed two-arrow one-shot outputs with held-key levels plus a generic event stream.

Parameters:
CLK_DIV, 250, clk cycles per sample tick (≥2)
TIMEOUT_TICKS, 4000, ticks without a ps2_clk falling edge before a partial frame is aborted
NUM_KEYS, 4, number of watched keys / key_held bits (1..16)
KEY_CODES, {9'h172,9'h175,9'h16B,9'h174}, packed 9-bit {ext,code} per watched key; index 0 in LSBs (default: right, left, up, down arrows)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
ps2_clk  in  1  raw PS/2 clock pin, asynchronous
ps2_data  in  1  raw PS/2 data pin, asynchronous
key_valid  out  1  one-clk pulse: complete key event
key_code  out  8  scan code of the event (held until the next event)
key_ext  out  1  event was E0-prefixed
key_break  out  1  event was F0-prefixed (release)
frame_error  out  1  one-clk pulse: parity, stop or timeout error
key_held  out  NUM_KEYS  level: watched key i is currently pressed

Behaviour:
- Reset: every output is 0, FSM is IDLE, all counters are 0, prefix flags are cleared, and the synchronisers are set to 1. Reset asserted mid-frame discards the partial frame with no error pulse.
- ps2_clk and ps2_data each pass through a 2-flop synchroniser on clk.
- Tick: a divider counts 0..CLK_DIV-1 and asserts tick for 1 clk at wrap. All sampling happens on tick.
- Falling edge: on a tick where the synced ps2_clk = 0 and the previous tick's sample = 1.
- FSM states and transitions, all taken on falling-edge ticks:
  - IDLE: data = 0 → DATA with bit count 0. Data = 1 → stay in IDLE, treated as a glitch.
  - DATA: shift data in LSB first. After the 8th bit → PARITY.
  - PARITY: capture the parity bit → STOP.
  - STOP: capture the stop bit → IDLE and evaluate the byte.
- Evaluation: the byte is good when the data byte plus the parity bit has odd weight and stop = 1. Otherwise frame_error pulses and both prefix flags clear.
- Timeout: a tick counter resets on each falling edge and counts only while the FSM is not IDLE. Reaching TIMEOUT_TICKS forces IDLE, pulses frame_error and clears the prefix flags.
- Good byte handling:
  - E0 sets ext_pending.
  - F0 sets brk_pending.
  - Any other byte latches key_code, key_ext = ext_pending and key_break = brk_pending, pulses key_valid, then clears both flags.
  - E0 F0 in either order combines both flags.
- Latency: key_valid and frame_error pulse exactly 2 clk after the tick that sampled the stop bit or the timeout. They are registered, high for exactly 1 clk, and never high together.
- key_held[i] updates in the same cycle key_valid pulses. It sets when {key_ext,key_code} == KEY_CODES[i] and key_break = 0, and clears on a matching break. If duplicate KEY_CODES entries exist, all matching bits update. Unmatched events leave key_held unchanged.
- Framing errors do not alter key_held.

Optional Feature:
PS2_TYPEMATIC_FILTER_EN
- Defined: a make event whose code matches a watched key already held suppresses the key_valid pulse. key_code, key_ext and key_break still do not change for the suppressed event. Breaks and non-watched keys are unaffected.
- Undefined: every make, including typematic repeats, pulses key_valid.

Test Plan:
- Frame 0x1C (start 0, data LSB-first, parity 0, stop 1) → one key_valid, key_code = 0x1C, key_ext = 0, key_break = 0, key_held = 4'b0000.
- Bytes E0, 74 → key_valid once (on the 74 only), key_ext = 1, key_code = 0x74, key_held = 4'b0001. Then E0, F0, 74 → key_break = 1, key_held = 4'b0000.
- 0x1C sent with parity bit 1 → frame_error pulses once, no key_valid. A following clean 0x1C decodes normally.
- Five bits sent, then ps2_clk held high for TIMEOUT_TICKS+10 ticks → frame_error pulses once and the FSM returns to IDLE. A next clean E0 6B sets key_held[1].
- E0 6B sent twice → with PS2_TYPEMATIC_FILTER_EN one key_valid, without it two. key_held[1] = 1 in both builds.
- rst asserted after 6 bits of a frame → all outputs 0 immediately. After release, a clean E0 75 yields key_held[2] = 1 and no frame_error.

Source files
------------

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
//   PS/2 keyboard receiver. It oversamples the raw PS/2 clock and data pins,
//   deframes 11-bit packets, and checks parity, the stop bit and inter-edge
//   timeout. It folds the E0 (extended) and F0 (break) prefixes into complete
//   key events, and tracks a held level for each of NUM_KEYS watched keys.
//
//   Optional build macro: PS2_TYPEMATIC_FILTER_EN
//     When defined, a make event for a watched key that is already held
//     (a typematic repeat) produces no key_valid pulse.
//
// Ports
//   clk          system clock
//   rst          asynchronous active-high reset
//   ps2_clk      raw PS/2 clock pin (asynchronous)
//   ps2_data     raw PS/2 data pin (asynchronous)
//   key_valid    one-clk pulse: complete key event
//   key_code     scan code of the last event
//   key_ext      last event was E0-prefixed
//   key_break    last event was F0-prefixed (release)
//   frame_error  one-clk pulse: parity, stop or timeout error
//   key_held     level per watched key: currently pressed
//
// state  | meaning
// IDLE   | waiting for a start bit (data low on a falling edge)
// DATA   | shifting in 8 data bits, LSB first
// PARITY | capturing the odd-parity bit
// STOP   | capturing the stop bit, then byte is evaluated
module ps2_key_decoder #(
   parameter int                    CLK_DIV       = 250,
   parameter int                    TIMEOUT_TICKS = 4000,
   parameter int                    NUM_KEYS      = 4,
   parameter logic [NUM_KEYS*9-1:0] KEY_CODES     = {9'h172, 9'h175, 9'h16B, 9'h174}
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ps2_clk,
   input  logic                ps2_data,
   output logic                key_valid,
   output logic [7:0]          key_code,
   output logic                key_ext,
   output logic                key_break,
   output logic                frame_error,
   output logic [NUM_KEYS-1:0] key_held
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int TO_W  = $clog2(TIMEOUT_TICKS + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_TICKS - 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   logic [1:0]          clk_sync;
   logic [1:0]          data_sync;
   logic                ps2_clk_s;
   logic                ps2_data_s;
   logic [DIV_W-1:0]    div_cnt;
   logic                tick;
   logic                clk_prev;
   logic                fall;

   state_t              state;
   logic [2:0]          bit_cnt;
   logic [7:0]          shift;
   logic                par_bit;
   logic                stop_bit;
   logic [TO_W-1:0]     to_cnt;
   logic                byte_done;
   logic                abort;
   logic                ext_pending;
   logic                brk_pending;
   logic                byte_good;
   logic [NUM_KEYS-1:0] match;
   logic                suppress;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_sync  <= 2'b11;
         data_sync <= 2'b11;
      end else begin
         clk_sync  <= {clk_sync[0], ps2_clk};
         data_sync <= {data_sync[0], ps2_data};
      end
   end

   assign ps2_clk_s  = clk_sync[1];
   assign ps2_data_s = data_sync[1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                    div_cnt <= '0;
      else if (div_cnt == DIV_LAST) div_cnt <= '0;
      else                        div_cnt <= div_cnt + 1'b1;
   end

   assign tick = (div_cnt == DIV_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       clk_prev <= 1'b1;
      else if (tick) clk_prev <= ps2_clk_s;
   end

   assign fall = tick & ~ps2_clk_s & clk_prev;

   // Odd parity over data+parity, and stop must be high.
   assign byte_good = (^{shift, par_bit}) & stop_bit;

   always_comb begin
      match = '0;
      for (int i = 0; i < NUM_KEYS; i++)
         match[i] = ({ext_pending, shift} == KEY_CODES[i*9 +: 9]);
   end

`ifdef PS2_TYPEMATIC_FILTER_EN
   assign suppress = ~brk_pending & (|(match & key_held));
`else
   assign suppress = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         bit_cnt     <= '0;
         shift       <= '0;
         par_bit     <= 1'b0;
         stop_bit    <= 1'b0;
         to_cnt      <= '0;
         byte_done   <= 1'b0;
         abort       <= 1'b0;
         ext_pending <= 1'b0;
         brk_pending <= 1'b0;
         key_valid   <= 1'b0;
         key_code    <= '0;
         key_ext     <= 1'b0;
         key_break   <= 1'b0;
         frame_error <= 1'b0;
         key_held    <= '0;
      end else begin
         byte_done   <= 1'b0;
         abort       <= 1'b0;
         key_valid   <= 1'b0;
         frame_error <= 1'b0;

         // Deframing; the shift register stays intact after STOP so the
         // byte can be evaluated on the following cycle.
         if (fall) begin
            to_cnt <= '0;
            case (state)
               IDLE: begin
                  if (!ps2_data_s) begin
                     state   <= DATA;
                     bit_cnt <= '0;
                  end
               end
               DATA: begin
                  shift   <= {ps2_data_s, shift[7:1]};
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == 3'd7) state <= PARITY;
               end
               PARITY: begin
                  par_bit <= ps2_data_s;
                  state   <= STOP;
               end
               default: begin
                  stop_bit  <= ps2_data_s;
                  state     <= IDLE;
                  byte_done <= 1'b1;
               end
            endcase
         end else if (state == IDLE) begin
            to_cnt <= '0;
         end else if (tick) begin
            if (to_cnt == TO_LAST) begin
               state  <= IDLE;
               to_cnt <= '0;
               abort  <= 1'b1;
            end else begin
               to_cnt <= to_cnt + 1'b1;
            end
         end

         // Byte evaluation, one cycle after the stop bit or timeout tick.
         if (abort) begin
            frame_error <= 1'b1;
            ext_pending <= 1'b0;
            brk_pending <= 1'b0;
         end else if (byte_done) begin
            if (!byte_good) begin
               frame_error <= 1'b1;
               ext_pending <= 1'b0;
               brk_pending <= 1'b0;
            end else if (shift == 8'hE0) begin
               ext_pending <= 1'b1;
            end else if (shift == 8'hF0) begin
               brk_pending <= 1'b1;
            end else begin
               ext_pending <= 1'b0;
               brk_pending <= 1'b0;
               if (!suppress) begin
                  key_valid <= 1'b1;
                  key_code  <= shift;
                  key_ext   <= ext_pending;
                  key_break <= brk_pending;
               end
               for (int i = 0; i < NUM_KEYS; i++)
                  if (match[i]) key_held[i] <= ~brk_pending;
            end
         end
      end
   end

endmodule

// File: tb/tb_ps2_key_decoder.sv
module tb_ps2_key_decoder;

   localparam int CLK_DIV  = 4;
   localparam int TO_TICKS = 50;
   localparam int HALF     = 3 * CLK_DIV;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       key_valid;
   logic [7:0] key_code;
   logic       key_ext;
   logic       key_break;
   logic       frame_error;
   logic [3:0] key_held;

   int checks = 0;
   int failures = 0;
   int kv_cnt = 0;
   int fe_cnt = 0;
   int both_cnt = 0;
   int wide_cnt = 0;
   logic kv_q = 1'b0;
   logic fe_q = 1'b0;

   ps2_key_decoder #(
      .CLK_DIV(CLK_DIV),
      .TIMEOUT_TICKS(TO_TICKS),
      .NUM_KEYS(4),
      .KEY_CODES({9'h172, 9'h175, 9'h16B, 9'h174})
   ) dut (
      .clk(clk),
      .rst(rst),
      .ps2_clk(ps2_clk),
      .ps2_data(ps2_data),
      .key_valid(key_valid),
      .key_code(key_code),
      .key_ext(key_ext),
      .key_break(key_break),
      .frame_error(frame_error),
      .key_held(key_held)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (key_valid === 1'b1) kv_cnt++;
      if (frame_error === 1'b1) fe_cnt++;
      if (key_valid === 1'b1 && frame_error === 1'b1) both_cnt++;
      if ((key_valid === 1'b1 && kv_q) || (frame_error === 1'b1 && fe_q)) wide_cnt++;
      kv_q = (key_valid === 1'b1);
      fe_q = (frame_error === 1'b1);
   end

   task automatic clear_counts();
      @(posedge clk);
      kv_cnt = 0;
      fe_cnt = 0;
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Sends the first nbits of an 11-bit frame, then idles the bus high.
   task automatic send_frame(input logic [7:0] b, input logic bad_par,
                             input logic stop, input int nbits);
      logic [10:0] bits;
      bits = {stop, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk);
         ps2_data = bits[i];
         ps2_clk  = 1'b1;
         wait_clk(HALF);
         ps2_clk = 1'b0;
         wait_clk(HALF);
      end
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      wait_clk(HALF);
   endtask

   task automatic send_byte(input logic [7:0] b);
      send_frame(b, 1'b0, 1'b1, 11);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      wait_clk(5);
      if ({key_valid, key_code, key_ext, key_break, frame_error, key_held} !== 16'h0) begin
         failures++;
         $display("FAIL reset_outputs got=%h want=0000",
                  {key_valid, key_code, key_ext, key_break, frame_error, key_held});
      end
      checks++;
      rst = 1'b0;
      wait_clk(10);
   endtask

   task automatic test_plain_make();
      clear_counts();
      send_byte(8'h1C);
      wait_clk(20);
      if (kv_cnt !== 1) begin failures++; $display("FAIL plain_kv_count got=%0d want=1", kv_cnt); end
      checks++;
      if ({key_ext, key_break, key_code} !== 10'h01C) begin
         failures++; $display("FAIL plain_event got=%h want=01c", {key_ext, key_break, key_code});
      end
      checks++;
      if (key_held !== 4'b0000) begin failures++; $display("FAIL plain_held got=%b want=0000", key_held); end
      checks++;
   endtask

   task automatic test_ext_keys();
      clear_counts();
      send_byte(8'hE0);
      send_byte(8'h74);
      wait_clk(20);
      if (kv_cnt !== 1) begin failures++; $display("FAIL ext_make_kv_count got=%0d want=1", kv_cnt); end
      checks++;
      if ({key_ext, key_break, key_code} !== 10'h274 || key_held !== 4'b0001) begin
         failures++;
         $display("FAIL ext_make got=%h held=%b want=274 held=0001", {key_ext, key_break, key_code}, key_held);
      end
      checks++;
      send_byte(8'hE0);
      send_byte(8'hF0);
      send_byte(8'h74);
      wait_clk(20);
      if ({key_ext, key_break, key_code} !== 10'h374 || key_held !== 4'b0000) begin
         failures++;
         $display("FAIL ext_break got=%h held=%b want=374 held=0000", {key_ext, key_break, key_code}, key_held);
      end
      checks++;
      send_byte(8'hE0);
      send_byte(8'h6B);
      wait_clk(20);
      if (key_held !== 4'b0010) begin failures++; $display("FAIL left_make_held got=%b want=0010", key_held); end
      checks++;
      send_byte(8'hF0);
      send_byte(8'hE0);
      send_byte(8'h6B);
      wait_clk(20);
      if ({key_ext, key_break, key_code} !== 10'h36B || key_held !== 4'b0000) begin
         failures++;
         $display("FAIL f0e0_break got=%h held=%b want=36b held=0000", {key_ext, key_break, key_code}, key_held);
      end
      checks++;
      if (kv_cnt !== 4 || fe_cnt !== 0) begin
         failures++; $display("FAIL ext_counts got kv=%0d fe=%0d want kv=4 fe=0", kv_cnt, fe_cnt);
      end
      checks++;
   endtask

   task automatic test_frame_errors();
      clear_counts();
      send_frame(8'h1C, 1'b1, 1'b1, 11);
      wait_clk(20);
      if (fe_cnt !== 1 || kv_cnt !== 0) begin
         failures++; $display("FAIL parity_err got fe=%0d kv=%0d want fe=1 kv=0", fe_cnt, kv_cnt);
      end
      checks++;
      clear_counts();
      send_byte(8'h1C);
      wait_clk(20);
      if (kv_cnt !== 1 || key_code !== 8'h1C || fe_cnt !== 0) begin
         failures++; $display("FAIL after_parity got kv=%0d code=%h fe=%0d want kv=1 code=1c fe=0", kv_cnt, key_code, fe_cnt);
      end
      checks++;
      clear_counts();
      send_byte(8'hE0);
      send_frame(8'h55, 1'b1, 1'b1, 11);
      send_byte(8'h74);
      wait_clk(20);
      if (kv_cnt !== 1 || fe_cnt !== 1 || {key_ext, key_break, key_code} !== 10'h074 || key_held !== 4'b0000) begin
         failures++;
         $display("FAIL prefix_clear got kv=%0d fe=%0d ev=%h held=%b want kv=1 fe=1 ev=074 held=0000",
                  kv_cnt, fe_cnt, {key_ext, key_break, key_code}, key_held);
      end
      checks++;
      clear_counts();
      send_frame(8'h1C, 1'b0, 1'b0, 11);
      wait_clk(20);
      if (fe_cnt !== 1 || kv_cnt !== 0) begin
         failures++; $display("FAIL stop_err got fe=%0d kv=%0d want fe=1 kv=0", fe_cnt, kv_cnt);
      end
      checks++;
   endtask

   task automatic test_timeout();
      clear_counts();
      send_frame(8'h1C, 1'b0, 1'b1, 5);
      wait_clk((TO_TICKS - 20) * CLK_DIV);
      if (fe_cnt !== 0) begin failures++; $display("FAIL timeout_early got fe=%0d want 0", fe_cnt); end
      checks++;
      wait_clk(30 * CLK_DIV);
      if (fe_cnt !== 1 || kv_cnt !== 0) begin
         failures++; $display("FAIL timeout_err got fe=%0d kv=%0d want fe=1 kv=0", fe_cnt, kv_cnt);
      end
      checks++;
      clear_counts();
      send_byte(8'hE0);
      send_byte(8'h6B);
      wait_clk(20);
      if (kv_cnt !== 1 || key_held !== 4'b0010 || {key_ext, key_break, key_code} !== 10'h26B) begin
         failures++;
         $display("FAIL after_timeout got kv=%0d held=%b ev=%h want kv=1 held=0010 ev=26b",
                  kv_cnt, key_held, {key_ext, key_break, key_code});
      end
      checks++;
   endtask

   task automatic test_typematic();
      int want_kv;
`ifdef PS2_TYPEMATIC_FILTER_EN
      want_kv = 1;
`else
      want_kv = 2;
`endif
      send_byte(8'hE0);
      send_byte(8'hF0);
      send_byte(8'h6B);
      wait_clk(20);
      if (key_held !== 4'b0000) begin failures++; $display("FAIL typ_release got=%b want=0000", key_held); end
      checks++;
      clear_counts();
      send_byte(8'hE0);
      send_byte(8'h6B);
      send_byte(8'hE0);
      send_byte(8'h6B);
      wait_clk(20);
      if (kv_cnt !== want_kv) begin
         failures++; $display("FAIL typ_kv_count got=%0d want=%0d", kv_cnt, want_kv);
      end
      checks++;
      if (key_held !== 4'b0010 || {key_ext, key_break, key_code} !== 10'h26B) begin
         failures++;
         $display("FAIL typ_state got held=%b ev=%h want held=0010 ev=26b", key_held, {key_ext, key_break, key_code});
      end
      checks++;
   endtask

   task automatic test_reset_midframe();
      send_frame(8'h1C, 1'b0, 1'b1, 6);
      @(negedge clk);
      rst = 1'b1;
      #1;
      if ({key_valid, key_code, key_ext, key_break, frame_error, key_held} !== 16'h0) begin
         failures++;
         $display("FAIL midframe_reset got=%h want=0000",
                  {key_valid, key_code, key_ext, key_break, frame_error, key_held});
      end
      checks++;
      wait_clk(4);
      rst = 1'b0;
      wait_clk(10);
      clear_counts();
      send_byte(8'hE0);
      send_byte(8'h75);
      wait_clk(20);
      if (key_held !== 4'b0100 || fe_cnt !== 0 || kv_cnt !== 1) begin
         failures++;
         $display("FAIL after_reset got held=%b fe=%0d kv=%0d want held=0100 fe=0 kv=1", key_held, fe_cnt, kv_cnt);
      end
      checks++;
   endtask

   task automatic test_pulse_shape();
      if (both_cnt !== 0 || wide_cnt !== 0) begin
         failures++; $display("FAIL pulse_shape got both=%0d wide=%0d want 0 0", both_cnt, wide_cnt);
      end
      checks++;
   endtask

   initial begin
      test_reset();
      test_plain_make();
      test_ext_keys();
      test_frame_errors();
      test_timeout();
      test_typematic();
      test_reset_midframe();
      test_pulse_shape();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
